axis_packet_arbiter: RTL

Four-input, packet-granular round-robin arbiter that shares one downstream AXI-Stream link between four upstream sources. A grant is held from the first accepted beat through the beat carrying `tlast`, so packets are never interleaved. Data, valid, ready and last pass combinationally between the granted source and the output, with no buffering. The block sits in front of any single-consumer stream stage (e.g. a loopback or DMA sink) that several producers must share.

---
 rtl/axis_packet_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/axis_packet_arbiter.sv
// Four-source, packet-granular round-robin AXI-Stream arbiter.
// A grant is held from the first beat through tlast; the payload passes combinationally.
module axis_packet_arbiter #(
    parameter int c_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4*c_WIDTH-1:0] s_axis_tdata,
    input  logic [3:0]           s_axis_tvalid,
    output logic [3:0]           s_axis_tready,
    input  logic [3:0]           s_axis_tlast,
    output logic [c_WIDTH-1:0]   m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic [1:0]           m_axis_tid,
    output logic                 busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             r_state;
    logic [1:0]         r_grant_idx;
    logic [1:0]         r_last;
    logic [1:0]         w_winner;
    logic               w_eop;
    logic [c_WIDTH-1:0] w_lane [4];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_lane[k] = s_axis_tdata[k*c_WIDTH +: c_WIDTH];
        end
    end

    // Walk from lowest priority (offset 4 == r_last) to highest (offset 1) so the
    // highest-priority requester is the final assignment that sticks.
    always_comb begin
        logic [1:0] cand;
        w_winner = r_last;
        cand     = r_last;
        for (int i = 4; i >= 1; i--) begin
            cand = r_last + 2'(i);
            if (s_axis_tvalid[cand]) begin
                w_winner = cand;
            end
        end
    end

    assign w_eop = (r_state == BUSY) && s_axis_tvalid[r_grant_idx]
                && m_axis_tready && s_axis_tlast[r_grant_idx];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grant_idx <= 2'd0;
            r_last      <= 2'd3;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|s_axis_tvalid) begin
                        r_grant_idx <= w_winner;
                        r_state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_eop) begin
                        r_last  <= r_grant_idx;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy       = (r_state == BUSY);
    assign m_axis_tid = r_grant_idx;

    // NOTE: every output gets a default before the conditional so no latch is inferred.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = 4'b0000;
        if (busy) begin
            m_axis_tdata               = w_lane[r_grant_idx];
            m_axis_tvalid              = s_axis_tvalid[r_grant_idx];
            m_axis_tlast               = s_axis_tlast[r_grant_idx];
            s_axis_tready[r_grant_idx] = m_axis_tready;
        end
    end

endmodule
